if_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID stage and the hazard detection unit. It owns the PC and issues single-beat requests to instruction memory using a variable-latency handshake. It applies the hazard unit's PC enable, IF/ID enable, stall and flush controls, and redirects on branches resolved in ID. Wrong-path fetches still in flight at a redirect are drained and discarded.

---
 rtl/if_stage.sv | 149 ++++++++++++++
 tb/tb_if_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC and fetches from instruction memory over a variable-latency req/rvalid handshake.
//
// state | meaning
// ------+-------------------------------------------------------------------
// RUN   | request outstanding at pc; the response is delivered, buffered or dropped
// HOLD  | fetched word parked in buf_inst until the pipeline can advance; no request
// DRAIN | wrong-path request still in flight; wait for its rvalid, then jump to redir_pc
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_EN_IF,
    input  logic        reg_FD_EN,
    input  logic        reg_FD_stall,
    input  logic        reg_FD_flush,
    input  logic        Branch_ID,
    input  logic [31:0] branch_target_ID,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_IF,
    output logic [31:0] PC_ID,
    output logic [31:0] inst_ID,
    output logic        valid_ID
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] buf_inst, buf_nxt;
    logic [31:0] redir_pc, redir_nxt;
    logic [31:0] pc_inc;
    logic [31:0] target;
    logic        adv;
    logic        redir;
    logic        deliver;
    logic [31:0] dlv_inst;

    assign adv    = PC_EN_IF & reg_FD_EN & ~reg_FD_stall;
    assign redir  = Branch_ID & PC_EN_IF;
    assign target = {branch_target_ID[31:2], 2'b00};
    assign pc_inc = pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= RESET_PC;
            buf_inst <= NOP;
            redir_pc <= 32'h0000_0000;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            buf_inst <= buf_nxt;
            redir_pc <= redir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        buf_nxt   = buf_inst;
        redir_nxt = redir_pc;
        deliver   = 1'b0;
        dlv_inst  = NOP;
        case (state)
            RUN: begin
                if (imem_rvalid) begin
                    if (redir) begin
                        pc_nxt = target;
                    end else if (adv) begin
                        deliver  = 1'b1;
                        dlv_inst = imem_rdata;
                        pc_nxt   = pc_inc;
                    end else begin
                        buf_nxt   = imem_rdata;
                        state_nxt = HOLD;
                    end
                end else if (redir) begin
                    redir_nxt = target;
                    state_nxt = DRAIN;
                end
            end
            HOLD: begin
                if (redir) begin
                    buf_nxt   = NOP;
                    pc_nxt    = target;
                    state_nxt = RUN;
                end else if (adv) begin
                    deliver   = 1'b1;
                    dlv_inst  = buf_inst;
                    pc_nxt    = pc_inc;
                    state_nxt = RUN;
                end
            end
            DRAIN: begin
                // A redirect arriving with the draining rvalid is the newest one, so it wins.
                if (imem_rvalid) begin
                    pc_nxt    = redir ? target : redir_pc;
                    state_nxt = RUN;
                end else if (redir) begin
                    redir_nxt = target;
                end
            end
            default: begin
                state_nxt = RUN;
                pc_nxt    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC_ID    <= 32'h0000_0000;
            inst_ID  <= NOP;
            valid_ID <= 1'b0;
        end else if (reg_FD_flush) begin
            PC_ID    <= 32'h0000_0000;
            inst_ID  <= NOP;
            valid_ID <= 1'b0;
        end else if (reg_FD_stall || !reg_FD_EN) begin
            PC_ID    <= PC_ID;
            inst_ID  <= inst_ID;
            valid_ID <= valid_ID;
        end else if (deliver) begin
            PC_ID    <= pc;
            inst_ID  <= dlv_inst;
            valid_ID <= 1'b1;
        end else begin
            PC_ID    <= 32'h0000_0000;
            inst_ID  <= NOP;
            valid_ID <= 1'b0;
        end
    end

    // Gated by rst_n so a request never appears while reset is held.
    assign imem_req  = rst_n & (state != HOLD);
    assign imem_addr = pc;
    assign PC_IF     = pc;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: zero/2-wait fetch, stall into HOLD, redirects, wrap, mid-wait reset.
// A small responder answers requests after wait_n cycles with address-derived data.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush;
    logic        Branch_ID;
    logic [31:0] branch_target_ID;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC_IF, PC_ID, inst_ID;
    logic        valid_ID;

    int          wait_n = 0;
    int          cnt = 0;
    logic        man_mode = 1'b0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    logic        spec_en = 1'b0;
    logic [31:0] spec_addr = 32'h0;
    logic [31:0] spec_data = 32'h0;

    int n_chk = 0;
    int n_fail = 0;

    if_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .PC_EN_IF         (PC_EN_IF),
        .reg_FD_EN        (reg_FD_EN),
        .reg_FD_stall     (reg_FD_stall),
        .reg_FD_flush     (reg_FD_flush),
        .Branch_ID        (Branch_ID),
        .branch_target_ID (branch_target_ID),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .PC_IF            (PC_IF),
        .PC_ID            (PC_ID),
        .inst_ID          (inst_ID),
        .valid_ID         (valid_ID)
    );

    always #5 clk = ~clk;

    assign imem_rvalid = man_mode ? man_rvalid : (imem_req && (cnt == wait_n));
    assign imem_rdata  = man_mode ? man_rdata :
                         (spec_en && imem_addr == spec_addr) ? spec_data :
                         (32'hA000_0000 | imem_addr);

    always @(posedge clk) begin
        if (!imem_req || imem_rvalid) cnt <= 0;
        else                          cnt <= cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        PC_EN_IF = 1'b1;
        reg_FD_EN = 1'b1;
        reg_FD_stall = 1'b0;
        reg_FD_flush = 1'b0;
        Branch_ID = 1'b0;
        branch_target_ID = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_req", imem_req, 0);
        check_val("rst_pc_if", PC_IF, 32'h0);
        check_val("rst_pc_id", PC_ID, 32'h0);
        check_val("rst_inst", inst_ID, NOP);
        check_val("rst_valid", valid_ID, 0);

        rst_n = 1'b1;
        #1;
        check_val("first_req", imem_req, 1);
        check_val("first_addr", imem_addr, 32'h0);

        // zero-wait: one instruction per cycle
        for (int i = 0; i < 2; i++) begin
            step();
            check_val("zw_valid", valid_ID, 1);
            check_val("zw_pc_id", PC_ID, i * 4);
            check_val("zw_inst", inst_ID, 32'hA000_0000 | (i * 4));
            check_val("zw_addr", imem_addr, (i + 1) * 4);
        end

        // stall while the word for PC 8 returns -> HOLD
        spec_en = 1'b1;
        spec_addr = 32'h8;
        spec_data = 32'h0050_0093;
        reg_FD_stall = 1'b1;
        PC_EN_IF = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("hold_req", imem_req, 0);
            check_val("hold_pc_if", PC_IF, 32'h8);
            check_val("hold_pc_id", PC_ID, 32'h4);
            check_val("hold_inst", inst_ID, 32'hA000_0004);
            check_val("hold_valid", valid_ID, 1);
        end
        reg_FD_stall = 1'b0;
        PC_EN_IF = 1'b1;
        #1;
        check_val("rel_req", imem_req, 0);
        step();
        check_val("rel_inst", inst_ID, 32'h0050_0093);
        check_val("rel_pc_id", PC_ID, 32'h8);
        check_val("rel_valid", valid_ID, 1);
        check_val("rel_req2", imem_req, 1);
        check_val("rel_addr", imem_addr, 32'hC);

        // 2-wait memory: address held 3 cycles, valid pattern 0,0,1
        wait_n = 2;
        for (int j = 0; j < 3; j++) begin
            check_val("w2_req", imem_req, 1);
            check_val("w2_addr", imem_addr, 32'hC);
            step();
            check_val("w2_valid", valid_ID, (j == 2) ? 1 : 0);
        end
        check_val("w2_pc_id", PC_ID, 32'hC);
        check_val("w2_inst", inst_ID, 32'hA000_000C);

        // redirect with request to 0x10 outstanding; flush beats stall
        check_val("br_addr0", imem_addr, 32'h10);
        Branch_ID = 1'b1;
        branch_target_ID = 32'h100;
        reg_FD_flush = 1'b1;
        reg_FD_stall = 1'b1;
        step();
        Branch_ID = 1'b0;
        reg_FD_flush = 1'b0;
        reg_FD_stall = 1'b0;
        check_val("fl_valid", valid_ID, 0);
        check_val("fl_inst", inst_ID, NOP);
        check_val("fl_pc_id", PC_ID, 32'h0);
        check_val("dr_addr1", imem_addr, 32'h10);
        check_val("dr_req1", imem_req, 1);
        step();
        check_val("dr_addr2", imem_addr, 32'h10);
        check_val("dr_valid2", valid_ID, 0);
        step();
        check_val("dr_valid3", valid_ID, 0);
        check_val("dr_tgt", imem_addr, 32'h100);
        check_val("dr_pc_if", PC_IF, 32'h100);

        // redirect with zero-wait completion; low target bits forced to 0
        wait_n = 0;
        Branch_ID = 1'b1;
        branch_target_ID = 32'h203;
        step();
        Branch_ID = 1'b0;
        check_val("br203_addr", imem_addr, 32'h200);
        check_val("br203_valid", valid_ID, 0);
        step();
        check_val("br203_pc_id", PC_ID, 32'h200);
        check_val("br203_inst", inst_ID, 32'hA000_0200);
        check_val("br203_vld", valid_ID, 1);

        // wrap from 0xFFFF_FFFC
        Branch_ID = 1'b1;
        branch_target_ID = 32'hFFFF_FFFC;
        step();
        Branch_ID = 1'b0;
        check_val("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check_val("wrap_pc_id", PC_ID, 32'hFFFF_FFFC);
        check_val("wrap_valid", valid_ID, 1);
        check_val("wrap_pc_if", PC_IF, 32'h0);
        step();
        check_val("wrap_pc_id0", PC_ID, 32'h0);
        check_val("wrap_addr4", imem_addr, 32'h4);

        // reset mid-wait with a stale rvalid
        wait_n = 2;
        step();
        step();
        check_val("mw_addr", imem_addr, 32'h4);
        rst_n = 1'b0;
        man_mode = 1'b1;
        man_rvalid = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        #1;
        check_val("mr_req", imem_req, 0);
        check_val("mr_pc_if", PC_IF, 32'h0);
        check_val("mr_valid", valid_ID, 0);
        check_val("mr_inst", inst_ID, NOP);
        check_val("mr_pc_id", PC_ID, 32'h0);
        step();
        check_val("mr_valid2", valid_ID, 0);
        check_val("mr_inst2", inst_ID, NOP);
        man_mode = 1'b0;
        man_rvalid = 1'b0;
        wait_n = 1;
        rst_n = 1'b1;
        #1;
        check_val("pr_req", imem_req, 1);
        check_val("pr_addr", imem_addr, 32'h0);
        check_val("pr_valid", valid_ID, 0);
        step();
        check_val("pr_valid1", valid_ID, 0);
        check_val("pr_addr1", imem_addr, 32'h0);
        step();
        check_val("pr_valid2", valid_ID, 1);
        check_val("pr_pc_id", PC_ID, 32'h0);
        check_val("pr_inst", inst_ID, 32'hA000_0000);
        check_val("pr_addr2", imem_addr, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
